// File: rtl/frogger_pkg.sv
// frogger_pkg: HID usage codes, PS/2 scancodes, frame-state enum and scancode-to-HID lookup.
package frogger_pkg;
    localparam logic [15:0] KEY_UP    = 16'h0052;
    localparam logic [15:0] KEY_DOWN  = 16'h0051;
    localparam logic [15:0] KEY_LEFT  = 16'h0050;
    localparam logic [15:0] KEY_RIGHT = 16'h004F;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_e;
    function automatic logic [15:0] scan_to_hid(input logic [7:0] sc);
        return sc == SC_UP    ? KEY_UP    :
               sc == SC_DOWN  ? KEY_DOWN  :
               sc == SC_LEFT  ? KEY_LEFT  :
               sc == SC_RIGHT ? KEY_RIGHT : 16'h0000;
    endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 line synchronizers, clock glitch filter, frame FSM and inactivity timeout.
// Odd-parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_frame_rx
    import frogger_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [1:0] clk_sync_q, dat_sync_q;
    logic filt_q;
    logic [FW-1:0] filt_cnt_q;
    frame_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic byte_valid_d, frame_err_d;
    logic ps2_c, ps2_d, flip, fall, timeout;
    assign ps2_c   = clk_sync_q[1];
    assign ps2_d   = dat_sync_q[1];
    // The filter counts a run of samples differing from the current level; the run's last sample flips it.
    assign flip    = (ps2_c != filt_q) && (filt_cnt_q == F_LAST);
    assign fall    = flip && filt_q;
    assign timeout = (state_q != IDLE) && !fall && (to_cnt_q == T_LAST);
    assign byte_o  = shift_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            filt_q     <= flip ? ps2_c : filt_q;
            filt_cnt_q <= (ps2_c == filt_q || flip) ? '0 : filt_cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            to_cnt_q     <= to_cnt_d;
            byte_valid_o <= byte_valid_d;
            frame_err_o  <= frame_err_d;
        end
    end
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        to_cnt_d     = (state_q == IDLE || fall) ? '0 : to_cnt_q + 1'b1;
        if (timeout) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    state_d     = ps2_d ? IDLE : DATA;
                    bit_cnt_d   = '0;
                    frame_err_d = ps2_d;
                end
                DATA: begin
                    shift_d   = {ps2_d, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = ps2_d;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
`ifdef PS2_PARITY_CHECK_EN
                    frame_err_d = !ps2_d || !(^{shift_q, par_q});
`else
                    frame_err_d = !ps2_d;
`endif
                    byte_valid_d = !frame_err_d;
                end
            endcase
        end
    end
endmodule

// File: rtl/ps2_keypad_rx.sv
// ps2_keypad_rx: PS/2 keyboard receiver reporting the held arrow key as a USB-HID usage code.
// Define PS2_PARITY_CHECK_EN to drop bytes that fail the odd-parity check.
module ps2_keypad_rx
    import frogger_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [15:0] keycode,
    output logic        key_valid,
    output logic        frame_err
);
    logic [7:0] rx_byte;
    logic byte_valid;
    logic ext_q, ext_d, brk_q, brk_d, key_valid_q, key_valid_d;
    logic [15:0] keycode_q, keycode_d, code;
    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame (
        .clk         (Clk),
        .rst         (Reset),
        .ps2_clk_i   (PS2_CLK),
        .ps2_dat_i   (PS2_DAT),
        .byte_o      (rx_byte),
        .byte_valid_o(byte_valid),
        .frame_err_o (frame_err)
    );
    assign code      = scan_to_hid(rx_byte);
    assign keycode   = keycode_q;
    assign key_valid = key_valid_q;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            keycode_q   <= '0;
            key_valid_q <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            keycode_q   <= keycode_d;
            key_valid_q <= key_valid_d;
        end
    end
    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        keycode_d   = keycode_q;
        key_valid_d = 1'b0;
        if (byte_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                // Only extended arrow codes matter; a repeated make or a foreign break is silent.
                if (ext_q && code != 16'h0000 && !brk_q && code != keycode_q) begin
                    keycode_d   = code;
                    key_valid_d = 1'b1;
                end else if (ext_q && code != 16'h0000 && brk_q && code == keycode_q) begin
                    keycode_d   = 16'h0000;
                    key_valid_d = 1'b1;
                end
            end
        end
    end
endmodule
